rx_fct_credit_ctrl: RTL and testbench



---
 rtl/rx_fct_credit_ctrl.sv | 164 ++++++++++++++++
 tb/tb_rx_fct_credit_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/rx_fct_credit_ctrl.sv
// rx_fct_credit_ctrl: SpaceWire RX flow-control sequencer.
// Moves decoded characters into the RX FIFO and tracks the credit granted to
// the far end. It asks TX for an FCT whenever the FIFO can absorb 8 more
// characters. A character that arrives with zero credit latches a sticky error.
// Optional build macro RX_FCT_STATS_EN adds saturating statistics counters.
module rx_fct_credit_ctrl #(
  parameter int FIFO_DEPTH  = 64,
  parameter int FREE_W      = 7,
  parameter int CREDIT_MAX  = 56,
  parameter int CREDIT_STEP = 8,
  parameter int CRED_W      = 6
) (
  input  logic              posedge_clk,
  input  logic              rx_resetn,
  input  logic              link_run,
  input  logic              rx_char_valid,
  input  logic [8:0]        rx_data_flag,
  input  logic [FREE_W-1:0] fifo_free,
  output logic              fifo_wr_en,
  output logic [8:0]        fifo_wr_data,
  output logic              fct_req,
  input  logic              fct_ack,
  output logic [CRED_W-1:0] credit_outstanding,
  output logic              rx_credit_err,
  output logic [1:0]        ctrl_state
`ifdef RX_FCT_STATS_EN
  ,
  output logic [15:0]       stat_chars,
  output logic [15:0]       stat_fcts,
  output logic [7:0]        stat_drops
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_REQ  = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  // One extra bit on each side so that credit + write + step cannot overflow.
  localparam int SUM_W = FREE_W + 1;
  localparam int CW1   = CRED_W + 1;

  localparam logic [SUM_W-1:0] DEPTH_S = SUM_W'(FIFO_DEPTH);
  localparam logic [SUM_W-1:0] STEP_S  = SUM_W'(CREDIT_STEP);
  localparam logic [CW1-1:0]   STEP_C  = CW1'(CREDIT_STEP);
  localparam logic [CW1-1:0]   MAX_C   = CW1'(CREDIT_MAX);

  logic [1:0]        state, state_n;
  logic [CRED_W-1:0] credit_n;
  logic              fct_req_n, err_n, wr_en_n;
  logic [8:0]        wr_data_n;
  logic              ack_take, grant;
  logic [SUM_W-1:0]  free_s;
  logic [CW1-1:0]    credit_ack, credit_dec;

  assign ctrl_state = state;

  // Next-state, credit arithmetic and grant decision.
  always_comb begin
    state_n    = state;
    credit_n   = credit_outstanding;
    fct_req_n  = fct_req;
    err_n      = rx_credit_err;
    wr_en_n    = 1'b0;
    wr_data_n  = fifo_wr_data;
    grant      = 1'b0;
    // A FIFO never reports more room than it has; clamp a misbehaving input.
    free_s     = (SUM_W'(fifo_free) > DEPTH_S) ? DEPTH_S : SUM_W'(fifo_free);
    // An ack only counts while our request is actually up.
    ack_take   = link_run && (state == S_REQ) && fct_req && fct_ack;
    // The ack is applied before any same-cycle character is charged.
    credit_ack = {1'b0, credit_outstanding} + (ack_take ? STEP_C : '0);
    if (credit_ack > MAX_C)
      credit_ack = MAX_C;
    credit_dec = credit_ack;

    if (!link_run) begin
      state_n   = S_IDLE;
      credit_n  = '0;
      fct_req_n = 1'b0;
      err_n     = 1'b0;
    end else begin
      case (state)
        S_IDLE: state_n = S_RUN;
        S_ERR: begin
          err_n     = 1'b1;
          fct_req_n = 1'b0;
        end
        default: begin
          if (rx_char_valid && (credit_ack == '0)) begin
            state_n   = S_ERR;
            err_n     = 1'b1;
            fct_req_n = 1'b0;
          end else begin
            if (rx_char_valid) begin
              credit_dec = credit_ack - CW1'(1);
              wr_en_n    = 1'b1;
              wr_data_n  = rx_data_flag;
            end
            credit_n = credit_dec[CRED_W-1:0];
            // Room for everything already promised, the write in flight and a new step.
            grant = (free_s >= (SUM_W'(credit_dec) + SUM_W'(fifo_wr_en) + STEP_S)) &&
                    ((credit_dec + STEP_C) <= MAX_C);
            if ((state == S_REQ) && !ack_take) begin
              fct_req_n = 1'b1;
            end else if ((state == S_RUN) && grant) begin
              state_n   = S_REQ;
              fct_req_n = 1'b1;
            end else begin
              // Returning from an ack always spends one cycle in S_RUN.
              state_n   = S_RUN;
              fct_req_n = 1'b0;
            end
          end
        end
      endcase
    end
  end

  // Registered state and outputs.
  always_ff @(posedge posedge_clk or negedge rx_resetn) begin
    if (!rx_resetn) begin
      state              <= S_IDLE;
      credit_outstanding <= '0;
      fct_req            <= 1'b0;
      rx_credit_err      <= 1'b0;
      fifo_wr_en         <= 1'b0;
      fifo_wr_data       <= '0;
    end else begin
      state              <= state_n;
      credit_outstanding <= credit_n;
      fct_req            <= fct_req_n;
      rx_credit_err      <= err_n;
      fifo_wr_en         <= wr_en_n;
      fifo_wr_data       <= wr_data_n;
    end
  end

`ifdef RX_FCT_STATS_EN
  logic drop;
  assign drop = link_run && rx_char_valid && ((state == S_IDLE) || (state == S_ERR));

  // Saturating statistics; cleared whenever the link is not running.
  always_ff @(posedge posedge_clk or negedge rx_resetn) begin
    if (!rx_resetn) begin
      stat_chars <= '0;
      stat_fcts  <= '0;
      stat_drops <= '0;
    end else if (!link_run) begin
      stat_chars <= '0;
      stat_fcts  <= '0;
      stat_drops <= '0;
    end else begin
      if (wr_en_n && (stat_chars != '1))
        stat_chars <= stat_chars + 16'd1;
      if (ack_take && (stat_fcts != '1))
        stat_fcts <= stat_fcts + 16'd1;
      if (drop && (stat_drops != '1))
        stat_drops <= stat_drops + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rx_fct_credit_ctrl.sv
// Bench for rx_fct_credit_ctrl: hand sequences for credit ramp, refill,
// simultaneous ack/char and async reset, plus a per-cycle vector table.
// FIFO writes go through a scoreboard queue checked for data and latency.
module tb_rx_fct_credit_ctrl;
  localparam int FREE_W = 7;
  localparam int CRED_W = 6;

  logic              posedge_clk = 1'b0;
  logic              rx_resetn = 1'b0;
  logic              link_run = 1'b0;
  logic              rx_char_valid = 1'b0;
  logic [8:0]        rx_data_flag = '0;
  logic [FREE_W-1:0] fifo_free = '0;
  logic              fct_ack = 1'b0;
  logic              fifo_wr_en;
  logic [8:0]        fifo_wr_data;
  logic              fct_req;
  logic [CRED_W-1:0] credit_outstanding;
  logic              rx_credit_err;
  logic [1:0]        ctrl_state;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct { logic [8:0] data; int due; } wr_t;
  wr_t sb[$];

  typedef struct { int lr; int v; int data; int free; int ack;
                   int st; int req; int cr; int err; int wr; } vec_t;
  vec_t vecs[$];

  rx_fct_credit_ctrl dut (
    .posedge_clk(posedge_clk), .rx_resetn(rx_resetn), .link_run(link_run),
    .rx_char_valid(rx_char_valid), .rx_data_flag(rx_data_flag), .fifo_free(fifo_free),
    .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data), .fct_req(fct_req),
    .fct_ack(fct_ack), .credit_outstanding(credit_outstanding),
    .rx_credit_err(rx_credit_err), .ctrl_state(ctrl_state)
  );

  always #5 posedge_clk = ~posedge_clk;
  always @(posedge posedge_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge posedge_clk);
    #1;
  endtask

  // Scoreboard consumer: every write must be expected, in order, on its due cycle.
  always @(negedge posedge_clk) begin
    wr_t e;
    if (fifo_wr_en) begin
      if (sb.size() == 0) chk("unexpected_write", 1, 0);
      else begin
        e = sb.pop_front();
        chk("wr_data", int'(fifo_wr_data), int'(e.data));
        chk("wr_latency", cyc, e.due);
      end
    end
  end

  task automatic auto_ack(input int ncyc, output int hs, output int maxc);
    hs = 0;
    maxc = 0;
    for (int i = 0; i < ncyc; i++) begin
      fct_ack = fct_req;
      tick();
      if (fct_ack) hs++;
      if (int'(credit_outstanding) > maxc) maxc = int'(credit_outstanding);
    end
    fct_ack = 1'b0;
  endtask

  task automatic send_chars(input logic [8:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      rx_char_valid = 1'b1;
      rx_data_flag  = base + 9'(i);
      sb.push_back('{rx_data_flag, cyc + 1});
      tick();
    end
    rx_char_valid = 1'b0;
  endtask

  task automatic wait_req(input int lim);
    for (int i = 0; i < lim && !fct_req; i++) tick();
    chk("fct_req_wait", int'(fct_req), 1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_state"}, int'(ctrl_state), 0);
    chk({tag, "_credit"}, int'(credit_outstanding), 0);
    chk({tag, "_req"}, int'(fct_req), 0);
    chk({tag, "_err"}, int'(rx_credit_err), 0);
    chk({tag, "_wr_en"}, int'(fifo_wr_en), 0);
    chk({tag, "_wr_data"}, int'(fifo_wr_data), 0);
  endtask

  initial begin
    int hs, maxc;
    // Per-cycle vectors: inputs for one edge, outputs expected after it.
    //              lr v  data   free ack  st req cr err wr
    vecs.push_back('{0, 0, 'h000, 64, 0,   0, 0,  0, 0, 0}); // link down
    vecs.push_back('{1, 1, 'h033, 64, 0,   1, 0,  0, 0, 0}); // char in IDLE dropped
    vecs.push_back('{1, 0, 'h000, 64, 0,   2, 1,  0, 0, 0}); // grant
    vecs.push_back('{1, 0, 'h000, 64, 0,   2, 1,  0, 0, 0}); // held, no ack
    vecs.push_back('{1, 1, 'h100, 64, 0,   3, 0,  0, 1, 0}); // zero-credit char
    vecs.push_back('{1, 1, 'h042, 64, 1,   3, 0,  0, 1, 0}); // ERR drops, ack ignored
    vecs.push_back('{0, 0, 'h000, 64, 0,   0, 0,  0, 0, 0}); // link down clears
    vecs.push_back('{1, 0, 'h000, 64, 0,   1, 0,  0, 0, 0});
    vecs.push_back('{1, 0, 'h000, 64, 0,   2, 1,  0, 0, 0});
    vecs.push_back('{1, 1, 'h101, 64, 1,   1, 0,  7, 0, 1}); // ack first at credit 0
    vecs.push_back('{1, 0, 'h000, 64, 1,   2, 1,  7, 0, 0}); // ack with req low ignored
    vecs.push_back('{1, 0, 'h000, 64, 1,   1, 0, 15, 0, 0});
    vecs.push_back('{1, 0, 'h000, 64, 0,   2, 1, 15, 0, 0});
    vecs.push_back('{1, 0, 'h000, 12, 0,   2, 1, 15, 0, 0});
    vecs.push_back('{1, 1, 'h0FF, 12, 1,   1, 0, 22, 0, 1}); // ack + char: +7
    vecs.push_back('{1, 0, 'h000, 12, 0,   1, 0, 22, 0, 0}); // FIFO room limits grant

    // Reset state.
    tick(); tick();
    chk_all_zero("reset");
    rx_resetn = 1'b1;
    tick();
    chk("post_reset_idle", int'(ctrl_state), 0);

    // Credit ramp to the maximum with prompt acks.
    fifo_free = 7'd64;
    link_run  = 1'b1;
    auto_ack(30, hs, maxc);
    chk("ramp_handshakes", hs, 7);
    chk("ramp_credit", int'(credit_outstanding), 56);
    chk("ramp_max_seen", maxc, 56);
    chk("ramp_req_idle", int'(fct_req), 0);

    // Eight characters, then a refill FCT once the FIFO reports room.
    fifo_free = 7'd56;
    send_chars(9'h041, 8);
    chk("chars_credit", int'(credit_outstanding), 48);
    wait_req(6);
    fct_ack = 1'b1; tick(); fct_ack = 1'b0;
    chk("refill_credit", int'(credit_outstanding), 56);
    chk("refill_req_drop", int'(fct_req), 0);

    // Ack and character in the same cycle at credit 48.
    send_chars(9'h051, 8);
    wait_req(6);
    chk("simul_pre_credit", int'(credit_outstanding), 48);
    fct_ack = 1'b1; rx_char_valid = 1'b1; rx_data_flag = 9'h0AA;
    sb.push_back('{9'h0AA, cyc + 1});
    tick();
    fct_ack = 1'b0; rx_char_valid = 1'b0;
    chk("simul_credit", int'(credit_outstanding), 55);
    chk("simul_state", int'(ctrl_state), 1);

    // Small FIFO: only one FCT fits.
    link_run = 1'b0; tick();
    chk("linkdown_credit", int'(credit_outstanding), 0);
    fifo_free = 7'd10;
    link_run  = 1'b1;
    auto_ack(20, hs, maxc);
    chk("small_fifo_handshakes", hs, 1);
    chk("small_fifo_credit", int'(credit_outstanding), 8);

    // Vector table.
    foreach (vecs[k]) begin
      link_run      = vecs[k].lr[0];
      rx_char_valid = vecs[k].v[0];
      rx_data_flag  = vecs[k].data[8:0];
      fifo_free     = vecs[k].free[FREE_W-1:0];
      fct_ack       = vecs[k].ack[0];
      if (vecs[k].wr != 0) sb.push_back('{vecs[k].data[8:0], cyc + 1});
      tick();
      chk($sformatf("vec%0d_state", k), int'(ctrl_state), vecs[k].st);
      chk($sformatf("vec%0d_req", k), int'(fct_req), vecs[k].req);
      chk($sformatf("vec%0d_credit", k), int'(credit_outstanding), vecs[k].cr);
      chk($sformatf("vec%0d_err", k), int'(rx_credit_err), vecs[k].err);
      chk($sformatf("vec%0d_wr_en", k), int'(fifo_wr_en), vecs[k].wr);
    end
    rx_char_valid = 1'b0; fct_ack = 1'b0;

    // Asynchronous reset while a request is pending.
    link_run = 1'b0; tick();
    link_run = 1'b1; fifo_free = 7'd64;
    tick(); tick();
    chk("pre_reset_state", int'(ctrl_state), 2);
    chk("pre_reset_req", int'(fct_req), 1);
    #1 rx_resetn = 1'b0; link_run = 1'b0;
    #1 chk_all_zero("async_reset");
    #1 rx_resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_idle", int'(ctrl_state), 0);
    end
    link_run = 1'b1;
    tick();
    chk("resume_run", int'(ctrl_state), 1);

    tick(); tick();
    chk("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop in case something above never returns.
  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
